// File: rtl/jtag_unlock_ctrl.sv
// Password-gated lock for the debug write path with timed sessions and lockout.
// Define JTAG_STICKY_LOCKOUT_EN to make lockout terminal until reset.
module jtag_unlock_ctrl #(
  parameter int KEY_W = 6,
  parameter int DATA_W = 6,
  parameter logic [KEY_W-1:0] KEY = 6'h2A,
  parameter int MAX_TRIES = 3,
  parameter int UNLOCK_CYCLES = 32,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [KEY_W-1:0]               req_key,
  input  logic                           relock,
  input  logic                           wr_req,
  input  logic [DATA_W-1:0]              wr_data,
  output logic [DATA_W-1:0]              o_data,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                        UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_UNL = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] TRIES = FW'(MAX_TRIES);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [KEY_W-1:0]  key_q, key_n;
  logic [TW-1:0]     timer, timer_n;
  logic [FW-1:0]     fail_n, fail_inc;
  logic [DATA_W-1:0] data_n;

  // Saturating increment so the bad-key count never wraps
  assign fail_inc = (fail_cnt == TRIES) ? fail_cnt : fail_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOCKED;
      key_q    <= '0;
      timer    <= '0;
      fail_cnt <= '0;
      o_data   <= '0;
    end else begin
      state    <= state_n;
      key_q    <= key_n;
      timer    <= timer_n;
      fail_cnt <= fail_n;
      o_data   <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = key_q;
    timer_n = timer;
    fail_n  = fail_cnt;
    data_n  = o_data;
    case (state)
      LOCKED: begin
        if (req_valid) begin
          key_n   = req_key;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (key_q == KEY) begin
          state_n = UNLOCKED;
          fail_n  = '0;
          timer_n = T_UNL;
        end else begin
          fail_n = fail_inc;
          if (fail_inc == TRIES) begin
            state_n = LOCKOUT;
            timer_n = T_LCK;
          end else begin
            state_n = LOCKED;
          end
        end
      end
      UNLOCKED: begin
        // Relock wins over a same-cycle write
        if (relock) begin
          state_n = LOCKED;
        end else begin
          if (wr_req) data_n = wr_data;
          if (timer == '0) state_n = LOCKED;
          else timer_n = timer - 1'b1;
        end
      end
      LOCKOUT: begin
`ifdef JTAG_STICKY_LOCKOUT_EN
        state_n = LOCKOUT;
`else
        if (timer == '0) begin
          state_n = LOCKED;
          fail_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
`endif
      end
      default: state_n = LOCKED;
    endcase
  end

  assign req_ready = (state == LOCKED);
  assign unlocked  = (state == UNLOCKED);
  assign lockout   = (state == LOCKOUT);

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Directed self-checking bench for jtag_unlock_ctrl.
// Honors JTAG_STICKY_LOCKOUT_EN for the lockout-duration expectations.
module tb_jtag_unlock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_key;
  logic       relock;
  logic       wr_req;
  logic [5:0] wr_data;
  logic [5:0] o_data;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_cnt;

  int tests = 0;
  int failed = 0;

  jtag_unlock_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .relock    (relock),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .o_data    (o_data),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input logic [5:0] k);
    req_valid = 1'b1;
    req_key   = k;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic ready_in_lockout;
    reset = 1'b1; req_valid = 1'b0; req_key = '0;
    relock = 1'b0; wr_req = 1'b0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_o_data", o_data, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_fail_cnt", fail_cnt, 0);

    // Writes ignored while locked
    wr_req = 1'b1; wr_data = 6'h15;
    repeat (5) tick();
    wr_req = 1'b0;
    chk("locked_wr_o_data", o_data, 0);
    chk("locked_wr_unlocked", unlocked, 0);

    // Good key; CHECK cycle has ready low
    req_valid = 1'b1; req_key = 6'h2A;
    tick();
    req_valid = 1'b0;
    chk("check_ready", req_ready, 0);
    chk("check_unlocked", unlocked, 0);
    tick();
    chk("unlock_t2", unlocked, 1);
    wr_req = 1'b1; wr_data = 6'h3C;
    tick();
    wr_req = 1'b0;
    chk("write_3c", o_data, 6'h3C);
    n = 2;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!unlocked) break;
      n++;
    end
    chk("unlock_len", n, 32);
    chk("after_unl_ready", req_ready, 1);
    chk("after_unl_hold", o_data, 6'h3C);

    // Write on the final session cycle is accepted
    submit(6'h2A);
    repeat (31) tick();
    chk("final_cycle_unl", unlocked, 1);
    wr_req = 1'b1; wr_data = 6'h2D;
    tick();
    wr_req = 1'b0;
    chk("final_cycle_wr", o_data, 6'h2D);
    chk("final_cycle_exit", unlocked, 0);

    // Relock with same-cycle write drops the write
    submit(6'h2A);
    chk("relock_pre", unlocked, 1);
    relock = 1'b1; wr_req = 1'b1; wr_data = 6'h07;
    tick();
    relock = 1'b0; wr_req = 1'b0;
    chk("relock_o_data", o_data, 6'h2D);
    chk("relock_unlocked", unlocked, 0);
    chk("relock_ready", req_ready, 1);

    // Three bad keys -> lockout
    submit(6'h00);
    chk("bad1_cnt", fail_cnt, 1);
    chk("bad1_ready", req_ready, 1);
    submit(6'h01);
    chk("bad2_cnt", fail_cnt, 2);
    submit(6'h02);
    chk("bad3_cnt", fail_cnt, 3);
    chk("bad3_lockout", lockout, 1);
    chk("bad3_ready", req_ready, 0);
    ready_in_lockout = 1'b0;
    req_valid = 1'b1; req_key = 6'h2A;
    n = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (!lockout) break;
      if (req_ready || unlocked) ready_in_lockout = 1'b1;
      n++;
    end
    req_valid = 1'b0;
    chk("lockout_refuses", ready_in_lockout, 0);
`ifdef JTAG_STICKY_LOCKOUT_EN
    chk("sticky_lockout", (n >= 100) ? 1 : 0, 1);
    chk("sticky_cnt", fail_cnt, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`else
    chk("lockout_len", n, 16);
    chk("lockout_cnt_clr", fail_cnt, 0);
    chk("lockout_ready", req_ready, 1);
`endif
    submit(6'h2A);
    chk("post_lockout_unl", unlocked, 1);
    relock = 1'b1;
    tick();
    relock = 1'b0;

    // Good key clears count; two more bad keys stay below lockout
    submit(6'h00);
    submit(6'h01);
    chk("two_bad_cnt", fail_cnt, 2);
    submit(6'h2A);
    chk("good_unl", unlocked, 1);
    chk("good_cnt_clr", fail_cnt, 0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    submit(6'h03);
    submit(6'h04);
    chk("no_lockout_cnt", fail_cnt, 2);
    chk("no_lockout", lockout, 0);
    chk("no_lockout_ready", req_ready, 1);

    // Reset mid-session
    submit(6'h2A);
    wr_req = 1'b1; wr_data = 6'h3C;
    tick();
    wr_req = 1'b0;
    chk("pre_rst_data", o_data, 6'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_sess_data", o_data, 0);
    chk("rst_sess_ready", req_ready, 1);
    chk("rst_sess_unl", unlocked, 0);

    // Reset mid-lockout
    submit(6'h11);
    submit(6'h12);
    submit(6'h13);
    chk("pre_rst_lockout", lockout, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_lk_lockout", lockout, 0);
    chk("rst_lk_cnt", fail_cnt, 0);
    chk("rst_lk_ready", req_ready, 1);
    chk("rst_lk_data", o_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
